// File: rtl/prediction_stat_tracker_pkg.sv
// Shared constants, record type and trend decoder for the prediction statistics tracker.
package prediction_stat_tracker_pkg;

  localparam int          HIT_INC    = 1;
  localparam int          MISS_DEC   = 2;
  localparam logic [1:0]  TREND_RST  = 2'b01;

  typedef struct packed {
    logic ghp;
    logic lhp;
    logic sp;
  } pred_rec_t;

  function automatic logic [3:0] trend_decode(input logic [1:0] hist);
    return 4'b0001 << hist;
  endfunction

endpackage

// File: rtl/prediction_stat_tracker_if.sv
// Fetch/execute handshake and statistics bundle between the tracker and its neighbours.
interface prediction_stat_tracker_if #(
  parameter int W = 5
);
  logic         push_valid;
  logic         push_ready;
  logic         push_sp;
  logic         push_lhp;
  logic         push_ghp;
  logic         resolve_valid;
  logic         resolve_taken;
  logic         flush;
  logic [W-1:0] SP_stat_count;
  logic [W-1:0] LHP_stat_count;
  logic [W-1:0] GHP_stat_count;
  logic [3:0]   SP_trend_decode;
  logic [3:0]   LHP_trend_decode;
  logic [3:0]   GHP_trend_decode;
  logic         resolve_underflow;

  modport master (
    output push_valid, push_sp, push_lhp, push_ghp, resolve_valid, resolve_taken, flush,
    input  push_ready, SP_stat_count, LHP_stat_count, GHP_stat_count,
           SP_trend_decode, LHP_trend_decode, GHP_trend_decode, resolve_underflow
  );

  modport slave (
    input  push_valid, push_sp, push_lhp, push_ghp, resolve_valid, resolve_taken, flush,
    output push_ready, SP_stat_count, LHP_stat_count, GHP_stat_count,
           SP_trend_decode, LHP_trend_decode, GHP_trend_decode, resolve_underflow
  );
endinterface

// File: rtl/prediction_stat_tracker_fifo.sv
// In-flight branch record FIFO: push/pop/flush with occupancy-derived full/empty.
module pred_record_fifo
  import prediction_stat_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  pred_rec_t rec_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output pred_rec_t rec_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  pred_rec_t     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;
  assign rec_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    // Flushed push never happens, so the write pointer is the surviving tail.
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rec_i;
  end

endmodule

// File: rtl/prediction_stat_tracker.sv
// Per-predictor saturating accuracy counters and 2-bit hit trends for the tournament arbiter.
// Optional periodic counter halving is built when STAT_DECAY_EN is defined.
module prediction_stat_tracker
  import prediction_stat_tracker_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int FIFO_DEPTH         = 4,
  parameter int DECAY_PERIOD       = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  prediction_stat_tracker_if.slave   bus
);
  localparam int           W       = STAT_COUNTER_WIDTH;
  localparam logic [W-1:0] CNT_MID = W'(1) << (W-1);
  localparam logic [W-1:0] CNT_MAX = '1;

  function automatic logic [W-1:0] sat_hit(input logic [W-1:0] cnt);
    return (cnt == CNT_MAX) ? CNT_MAX : cnt + W'(HIT_INC);
  endfunction

  function automatic logic [W-1:0] sat_miss(input logic [W-1:0] cnt);
    return (cnt < W'(MISS_DEC)) ? '0 : cnt - W'(MISS_DEC);
  endfunction

  pred_rec_t    push_rec, head_rec;
  logic         fifo_full, fifo_empty, pop_en;
  logic [2:0]   pred, hit;
  logic [W-1:0] cnt_q [3];
  logic [W-1:0] cnt_d [3];
  logic [1:0]   hist_q [3];
  logic [1:0]   hist_d [3];
  logic         underflow_q, underflow_d;

  assign push_rec = '{ghp: bus.push_ghp, lhp: bus.push_lhp, sp: bus.push_sp};

  pred_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.push_valid),
    .rec_i   (push_rec),
    .pop_i   (bus.resolve_valid),
    .flush_i (bus.flush),
    .rec_o   (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop_en      = bus.resolve_valid && !fifo_empty;
  assign pred        = {head_rec.ghp, head_rec.lhp, head_rec.sp};
  assign hit         = ~(pred ^ {3{bus.resolve_taken}});
  assign underflow_d = bus.resolve_valid && fifo_empty;

`ifdef STAT_DECAY_EN
  localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          decay_now;

  assign decay_now = pop_en && (dcnt_q == DW'(DECAY_PERIOD - 1));

  always_comb begin
    dcnt_d = dcnt_q;
    if (decay_now)   dcnt_d = '0;
    else if (pop_en) dcnt_d = dcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt_q <= '0;
    else        dcnt_q <= dcnt_d;
  end
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]  = cnt_q[i];
      hist_d[i] = hist_q[i];
      if (pop_en) begin
        cnt_d[i]  = hit[i] ? sat_hit(cnt_q[i]) : sat_miss(cnt_q[i]);
        hist_d[i] = {hist_q[i][0], hit[i]};
      end
`ifdef STAT_DECAY_EN
      // Halving applies on top of this resolve's own update.
      if (decay_now) cnt_d[i] = cnt_d[i] >> 1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]  <= CNT_MID;
        hist_q[i] <= TREND_RST;
      end
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hist_q[i] <= hist_d[i];
      end
      underflow_q <= underflow_d;
    end
  end

  assign bus.push_ready        = !fifo_full;
  assign bus.SP_stat_count     = cnt_q[0];
  assign bus.LHP_stat_count    = cnt_q[1];
  assign bus.GHP_stat_count    = cnt_q[2];
  assign bus.SP_trend_decode   = trend_decode(hist_q[0]);
  assign bus.LHP_trend_decode  = trend_decode(hist_q[1]);
  assign bus.GHP_trend_decode  = trend_decode(hist_q[2]);
  assign bus.resolve_underflow = underflow_q;

endmodule

// File: doc/prediction_stat_tracker.md
Name: prediction_stat_tracker

Overview:
Maintains the per-predictor accuracy statistics consumed by the tournament prediction arbiter: three saturating stat counters (SP, LHP, GHP) and three 2-bit hit/miss trend histories, decoded one-hot.
- Fetch pushes the three raw predictions of each in-flight branch into an internal record FIFO.
- Execute resolves branches in program order; each resolution pops the oldest record and updates statistics.
- Pipeline flush discards unresolved records.

Parameters:
STAT_COUNTER_WIDTH, 5, width of each stat counter (matches arbiter).
FIFO_DEPTH, 4, in-flight branch records; power of two, >= 2.
DECAY_PERIOD, 64, resolutions between counter halvings (only with STAT_DECAY_EN).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
push_valid  in  1  fetch has a predicted branch this cycle.
push_ready  out  1  FIFO not full.
push_sp  in  1  SP prediction (1 = taken).
push_lhp  in  1  LHP prediction.
push_ghp  in  1  GHP prediction.
resolve_valid  in  1  oldest branch resolved this cycle.
resolve_taken  in  1  actual outcome.
flush  in  1  discard all unresolved records.
SP_stat_count  out  STAT_COUNTER_WIDTH  SP counter.
LHP_stat_count  out  STAT_COUNTER_WIDTH  LHP counter.
GHP_stat_count  out  STAT_COUNTER_WIDTH  GHP counter.
SP_trend_decode  out  4  one-hot SP trend.
LHP_trend_decode  out  4  one-hot LHP trend.
GHP_trend_decode  out  4  one-hot GHP trend.
resolve_underflow  out  1  registered pulse: resolve_valid seen while FIFO empty.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty.
  - All counters = 2^(W-1) (16 at W=5).
  - All histories = 2'b01; decode = 4'b0010.
  - resolve_underflow = 0; decay counter = 0.
  - push_ready = 1.
- Push: a record is written when push_valid && push_ready. push_ready = !full, combinational from occupancy only, with no dependence on same-cycle pop.
- Resolve: the oldest record is popped when resolve_valid && !empty. Per predictor, hit = (pred == resolve_taken). Statistics update on the same edge.
  - Counter on hit: +1, saturating at 2^W-1.
  - Counter on miss: -2, saturating at 0.
  - History: hist <= {hist[0], hit}, so bit1 = older and bit0 = newer.
  - Decode: trend_decode = 1 << hist. Bit0 means two consecutive misses; bits 3/2 mean the older result was a hit.
- Latency: stats outputs are registered and reflect a resolve on the cycle after resolve_valid.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full (push_ready is already 0 when full, so no push occurs).
  - Allowed when empty; the pushed record is not poppable the same cycle and counts as underflow.
- resolve_valid while empty: no stat change; resolve_underflow = 1 for one cycle.
- Flush:
  - A resolve in the same cycle is processed first; it is architecturally older than the flush.
  - Then the FIFO clears: read pointer = write pointer, count = 0.
  - A push in the same cycle is dropped.
  - Statistics are never cleared by flush.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- rst_n asserted mid-operation: everything returns to reset values immediately; in-flight records are lost.

Optional Feature:
STAT_DECAY_EN
- Defined:
  - A decay counter counts accepted resolutions.
  - When it reaches DECAY_PERIOD-1 and another resolve is accepted, that resolve's update is applied first, then all three counters are shifted right by 1 on the same edge, and the decay counter returns to 0.
  - Histories are unaffected.
- Undefined: no decay counter exists; counters change only on resolve.

Decomposition:
- define.v: STAT counter reset midpoint, hit/miss increment constants (+1 / -2), trend history reset value 2'b01.
- One sub-module, pred_record_fifo: 3-bit-wide synchronous FIFO with push/pop/flush, full/empty, same async active-low reset.
- The top level holds the counter/history update logic and the optional decay counter.

Test Plan:
- Reset release (W=5), idle 3 cycles -> all counts 16, all decodes 4'b0010, push_ready=1, resolve_underflow=0.
- Push 4 records {SP=1,LHP=0,GHP=1} without resolve (DEPTH=4) -> push_ready=0 after 4th; 5th push with push_valid=1 not stored (the following 4 resolves drain exactly 4 records, then underflow).
- Resolve 2 records with resolve_taken=1 -> SP=18, LHP=12, GHP=18; decodes SP=GHP=4'b1000, LHP=4'b0001.
- Saturation: 20 consecutive SP hits -> SP_stat_count=31 and holds; 20 consecutive SP misses -> 0 and holds.
- Flush with 3 records queued, same cycle resolve_valid=1 and push_valid=1 -> oldest record updates stats, FIFO empty next cycle, pushed record dropped; next resolve_valid gives resolve_underflow=1 with stats unchanged.
- STAT_DECAY_EN, DECAY_PERIOD=4: 4 all-hit resolves from reset -> after 4th edge counts = (16+4)>>1 = 10.
